draw_plotter: RTL and testbench
===============================

# draw_plotter

Pixel-writing back end for the movement controller. Accepts a sprite position and an erase flag through a request/ready handshake and emits one pixel write per cycle to the VGA adapter's plot port. Paints a SIZE×SIZE square in the foreground colour, or in the background colour when erasing. Also performs a full-screen background clear after reset or on request.

## Interface

Parameters:
- SIZE, 6: sprite edge length in pixels
- SCREEN_W, 160: visible width
- SCREEN_H, 120: visible height
- FG, 3'b111: sprite colour
- BG, 3'b000: background and erase colour

Ports:
- clock  in  1  sole clock, rising edge
- reset_n  in  1  synchronous, active-high reset (asserted = 1)
- req  in  1  draw request, sampled only when ready=1
- undraw  in  1  erase flag, latched with req
- x_in  in  8  sprite top-left x, latched with req
- y_in  in  7  sprite top-left y, latched with req
- clear_req  in  1  full-screen clear request, sampled only when ready=1
- ready  out  1  idle and accepting requests
- plot  out  1  pixel write strobe to the VGA adapter
- x_out  out  8  pixel x
- y_out  out  7  pixel y
- colour_out  out  3  pixel colour
- done  out  1  one-cycle pulse when a draw or clear completes

## Operation

- States: CLEAR, DRAW, DONE, IDLE.
- Reset: state=CLEAR, counters=0, plot=0, done=0, ready=0, x_out=0, y_out=0, colour_out=BG.
- CLEAR: raster sweep, x fastest, over (0..SCREEN_W-1, 0..SCREEN_H-1), colour BG, one pixel per cycle. Produces 19200 writes. After the last pixel at (159,119) → DONE.
- IDLE: ready=1, plot=0.
  - clear_req=1 → CLEAR. clear_req takes priority over req.
  - Otherwise req=1 latches x_in, y_in and undraw, then → DRAW.
- DRAW: row-major sweep with offsets cx,cy in 0..SIZE-1.
  - Pixel = (x_base+cx, y_base+cy).
  - colour_out = BG if the latched undraw=1, else FG.
  - After cx=cy=SIZE-1 → DONE.
- Clipping: sums are computed at 9 bits for x and 8 bits for y. A pixel with x≥SCREEN_W or y≥SCREEN_H gets plot=0, but the sweep still advances, so DRAW duration is fixed. x_out and y_out carry the truncated sum.
- DONE: done=1 and plot=0 for exactly one cycle, then → IDLE.
- req and clear_req are ignored outside IDLE. They are not queued.
- reset_n asserted in any state aborts the current sweep and restarts at CLEAR.
- Input changes after acceptance do not affect the sprite in progress.

## Timing

- All outputs are registered.
- Request accepted on edge k, meaning ready=1 and req=1 in the preceding cycle.
  - First DRAW pixel is valid with plot=1 in cycle k+1.
  - Last pixel is in cycle k+SIZE².
  - done=1 in cycle k+SIZE²+1.
  - ready=1 from cycle k+SIZE²+2.
- ready drops in the cycle after acceptance. Back-to-back requests are therefore spaced SIZE²+2 cycles apart (38 for SIZE=6).
- After reset is released, the pixel (0,0) write appears on the first following edge. done follows 19200 cycles later, and ready one cycle after that.
- Throughput is one pixel per clock. There is no backpressure from the VGA adapter.

## Structure

- Shared package draw_pkg holds:
  - SCREEN_W and SCREEN_H
  - FG and BG colour constants
  - the plotter state encoding
  - the position limits used by the movement controller: x max 154, y max 114, so that limit+SIZE equals the screen size
- Sub-module pixel_counter_2d: a row-major x/y counter with run-time width and height, clear and enable inputs, and a last output. One instance is shared by CLEAR (SCREEN_W×SCREEN_H) and DRAW (SIZE×SIZE).
- The FSM, the base-position latch and the output registers stay in draw_plotter.

## Test plan

- Reset release → exactly 19200 plot cycles, all colour 000.
  - First write at (0,0), last at (159,119).
  - done pulses once, then ready=1.
- From IDLE, req with x_in=5, y_in=5, undraw=0 → 36 consecutive writes.
  - Covers x 5..10 and y 5..10 in row-major order, colour 111.
  - done at cycle 37 after acceptance.
  - Changing x_in mid-draw has no effect.
- req with x_in=4, y_in=5, undraw=1 → 36 writes over x 4..9 and y 5..10, colour 000.
- req with x_in=157, y_in=118 → still 36 cycles.
  - plot=1 only for the 6 pixels x 157..159, y 118..119.
  - done at cycle 37.
- Clear priority and ignored requests:
  - req=1 and clear_req=1 in the same IDLE cycle → full clear runs; the sprite is not drawn.
  - req pulsed during DRAW → ignored; no second sprite.
- reset_n pulsed during cycle 10 of a DRAW → the draw is aborted, with no done for it, and a full 19200-pixel clear restarts from (0,0).

Source files
------------

// File: rtl/draw_pkg.sv
// Shared constants and plotter state encoding for the sprite drawing path.
// Also carries the sprite position limits used by the movement controller.
package draw_pkg;

  localparam int SCREEN_W    = 160;
  localparam int SCREEN_H    = 120;
  localparam int SPRITE_SIZE = 6;

  localparam logic [2:0] FG = 3'b111;
  localparam logic [2:0] BG = 3'b000;

  // Largest top-left position that keeps the whole sprite on screen.
  localparam int X_MAX = SCREEN_W - SPRITE_SIZE;
  localparam int Y_MAX = SCREEN_H - SPRITE_SIZE;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_DRAW  = 2'd1,
    ST_DONE  = 2'd2,
    ST_IDLE  = 2'd3
  } plot_state_e;

endpackage

// File: rtl/pixel_counter_2d.sv
// Row-major x/y sweep counter with run-time extent; x advances fastest.
// last flags the final coordinate (width-1, height-1) of the sweep.
module pixel_counter_2d #(
  parameter int XW = 8,
  parameter int YW = 7
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  input  logic [XW-1:0] width,
  input  logic [YW-1:0] height,
  output logic [XW-1:0] cx,
  output logic [YW-1:0] cy,
  output logic          last
);

  localparam logic [XW-1:0] X_ONE = 1;
  localparam logic [YW-1:0] Y_ONE = 1;

  logic [XW-1:0] cx_q, cx_d;
  logic [YW-1:0] cy_q, cy_d;
  logic          row_end;

  always_comb begin
    cx_d    = cx_q;
    cy_d    = cy_q;
    row_end = (cx_q == width - X_ONE);
    last    = row_end && (cy_q == height - Y_ONE);
    if (clr) begin
      cx_d = '0;
      cy_d = '0;
    end else if (en) begin
      if (row_end) begin
        cx_d = '0;
        cy_d = last ? '0 : cy_q + Y_ONE;
      end else begin
        cx_d = cx_q + X_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cx_q <= '0;
      cy_q <= '0;
    end else begin
      cx_q <= cx_d;
      cy_q <= cy_d;
    end
  end

  assign cx = cx_q;
  assign cy = cy_q;

endmodule

// File: rtl/draw_plotter.sv
// Pixel-writing back end: full-screen clear and SIZE x SIZE sprite draw/erase,
// one registered pixel write per clock towards the VGA adapter's plot port.
module draw_plotter
  import draw_pkg::*;
#(
  parameter int         SIZE     = draw_pkg::SPRITE_SIZE,
  parameter int         SCREEN_W = draw_pkg::SCREEN_W,
  parameter int         SCREEN_H = draw_pkg::SCREEN_H,
  parameter logic [2:0] FG       = draw_pkg::FG,
  parameter logic [2:0] BG       = draw_pkg::BG
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       req,
  input  logic       undraw,
  input  logic [7:0] x_in,
  input  logic [6:0] y_in,
  input  logic       clear_req,
  output logic       ready,
  output logic       plot,
  output logic [7:0] x_out,
  output logic [6:0] y_out,
  output logic [2:0] colour_out,
  output logic       done
);

  // Handshake: req/clear_req are taken on a rising edge only while ready=1;
  // ready falls in the cycle after acceptance and nothing is queued.
  plot_state_e state_q, state_d;

  logic [7:0] xb_q, xb_d;
  logic [6:0] yb_q, yb_d;
  logic       erase_q, erase_d;
  logic       plot_q, plot_d;
  logic       done_q, done_d;
  logic       ready_q, ready_d;
  logic [7:0] x_q, x_d;
  logic [6:0] y_q, y_d;
  logic [2:0] col_q, col_d;

  logic [7:0] cx, cnt_w;
  logic [6:0] cy, cnt_h;
  logic       cnt_last, cnt_clr, cnt_en;
  logic [8:0] sum_x;
  logic [7:0] sum_y;

  pixel_counter_2d #(.XW(8), .YW(7)) u_cnt (
    .clk    (clock),
    .rst    (reset_n),
    .clr    (cnt_clr),
    .en     (cnt_en),
    .width  (cnt_w),
    .height (cnt_h),
    .cx     (cx),
    .cy     (cy),
    .last   (cnt_last)
  );

  always_comb begin
    state_d = state_q;
    xb_d    = xb_q;
    yb_d    = yb_q;
    erase_d = erase_q;
    x_d     = x_q;
    y_d     = y_q;
    col_d   = col_q;
    plot_d  = 1'b0;
    done_d  = 1'b0;
    ready_d = 1'b0;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    cnt_w   = 8'(SIZE);
    cnt_h   = 7'(SIZE);
    // Widened sums so off-screen pixels are detected instead of wrapping.
    sum_x   = {1'b0, xb_q} + {1'b0, cx};
    sum_y   = {1'b0, yb_q} + {1'b0, cy};
    case (state_q)
      ST_CLEAR: begin
        cnt_w  = 8'(SCREEN_W);
        cnt_h  = 7'(SCREEN_H);
        cnt_en = 1'b1;
        plot_d = 1'b1;
        x_d    = cx;
        y_d    = cy;
        col_d  = BG;
        if (cnt_last) state_d = ST_DONE;
      end
      ST_DRAW: begin
        cnt_en = 1'b1;
        plot_d = (sum_x < 9'(SCREEN_W)) && (sum_y < 8'(SCREEN_H));
        x_d    = sum_x[7:0];
        y_d    = sum_y[6:0];
        col_d  = erase_q ? BG : FG;
        if (cnt_last) state_d = ST_DONE;
      end
      ST_DONE: begin
        cnt_clr = 1'b1;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      ST_IDLE: begin
        cnt_clr = 1'b1;
        if (ready_q && clear_req) begin
          state_d = ST_CLEAR;
        end else if (ready_q && req) begin
          state_d = ST_DRAW;
          xb_d    = x_in;
          yb_d    = y_in;
          erase_d = undraw;
        end else begin
          ready_d = 1'b1;
        end
      end
      default: state_d = ST_CLEAR;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset_n) begin
      state_q <= ST_CLEAR;
      xb_q    <= '0;
      yb_q    <= '0;
      erase_q <= 1'b0;
      plot_q  <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      col_q   <= BG;
    end else begin
      state_q <= state_d;
      xb_q    <= xb_d;
      yb_q    <= yb_d;
      erase_q <= erase_d;
      plot_q  <= plot_d;
      done_q  <= done_d;
      ready_q <= ready_d;
      x_q     <= x_d;
      y_q     <= y_d;
      col_q   <= col_d;
    end
  end

  assign ready      = ready_q;
  assign plot       = plot_q;
  assign done       = done_q;
  assign x_out      = x_q;
  assign y_out      = y_q;
  assign colour_out = col_q;

endmodule

// File: tb/tb_draw_plotter.sv
// Randomised bench for draw_plotter: a sweep model fills an expected-write
// queue and a done-cycle queue; a negedge monitor pops and compares.
module tb_draw_plotter;
  import draw_pkg::*;

  localparam int W  = 50;  // {cycle[31:0], x[7:0], y[6:0], colour[2:0]}
  localparam int SZ = 6;

  logic       clock = 1'b0;
  logic       reset_n = 1'b1;
  logic       req = 1'b0;
  logic       undraw = 1'b0;
  logic [7:0] x_in = '0;
  logic [6:0] y_in = '0;
  logic       clear_req = 1'b0;
  logic       ready, plot, done;
  logic [7:0] x_out;
  logic [6:0] y_out;
  logic [2:0] colour_out;

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int exp_ready = 0;
  logic [W-1:0] exp_q[$];
  int done_q[$];

  draw_plotter dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .req        (req),
    .undraw     (undraw),
    .x_in       (x_in),
    .y_in       (y_in),
    .clear_req  (clear_req),
    .ready      (ready),
    .plot       (plot),
    .x_out      (x_out),
    .y_out      (y_out),
    .colour_out (colour_out),
    .done       (done)
  );

  // clock / reset block
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Reference model: a sweep accepted on edge k writes pixel i in cycle k+1+i,
  // skipping off-screen pixels; done in k+w*h+1, ready again in k+w*h+2.
  task automatic push_sweep(input int k, input int xb, input int yb, input int w,
                            input int h, input logic [2:0] col);
    int px, py, t;
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        px = xb + c;
        py = yb + r;
        t  = k + 1 + r * w + c;
        if (px < SCREEN_W && py < SCREEN_H)
          exp_q.push_back({t[31:0], px[7:0], py[6:0], col});
      end
    end
    done_q.push_back(k + w * h + 1);
    exp_ready = k + w * h + 2;
  endtask

  task automatic check(input string name, input int act, input int expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (cyc %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic check_reset_outputs();
    check("rst_plot", int'(plot), 0);
    check("rst_done", int'(done), 0);
    check("rst_ready", int'(ready), 0);
    check("rst_x", int'(x_out), 0);
    check("rst_y", int'(y_out), 0);
    check("rst_colour", int'(colour_out), int'(BG));
  endtask

  // driver tasks
  task automatic release_reset();
    reset_n = 1'b0;
    push_sweep(cyc, 0, 0, SCREEN_W, SCREEN_H, BG);
  endtask

  // Junk is driven on the request inputs while busy; it must all be ignored.
  task automatic wait_ready(input int bound);
    int n;
    n = 0;
    while (!ready && n < bound) begin
      req       = 1'($urandom_range(0, 1));
      clear_req = 1'($urandom_range(0, 1));
      x_in      = 8'($urandom);
      y_in      = 7'($urandom);
      undraw    = 1'($urandom);
      @(negedge clock); #1;
      n++;
    end
    req       = 1'b0;
    clear_req = 1'b0;
    if (!ready) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout actual=0 expected=1 after %0d cycles", bound);
    end else begin
      check("ready_cycle", cyc, exp_ready);
    end
  endtask

  task automatic issue(input logic [7:0] x, input logic [6:0] y, input logic u,
                       input logic rq, input logic cr);
    int k;
    req = rq; clear_req = cr; x_in = x; y_in = y; undraw = u;
    @(negedge clock); #1;
    k = cyc;
    req = 1'b0; clear_req = 1'b0;
    if (cr) push_sweep(k, 0, 0, SCREEN_W, SCREEN_H, BG);
    else    push_sweep(k, int'(x), int'(y), SZ, SZ, u ? BG : FG);
    check("ready_drop", int'(ready), 0);
  endtask

  // scoreboard monitor
  always @(negedge clock) begin
    logic [W-1:0] e, a;
    int dc;
    if (plot) begin
      checks++;
      a = {cyc[31:0], x_out, y_out, colour_out};
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL plot_unexpected actual cyc=%0d x=%0d y=%0d col=%0d required no write",
                 cyc, x_out, y_out, colour_out);
      end else begin
        e = exp_q.pop_front();
        if (a !== e) begin
          errors++;
          $display("FAIL pixel actual cyc=%0d x=%0d y=%0d col=%0d required cyc=%0d x=%0d y=%0d col=%0d",
                   a[49:18], a[17:10], a[9:3], a[2:0], e[49:18], e[17:10], e[9:3], e[2:0]);
        end
      end
    end
    if (done) begin
      checks++;
      if (done_q.size() == 0) begin
        errors++;
        $display("FAIL done_unexpected actual cyc=%0d required none", cyc);
      end else begin
        dc = done_q.pop_front();
        if (dc != cyc) begin
          errors++;
          $display("FAIL done_cycle actual=%0d required=%0d", cyc, dc);
        end
      end
    end
  end

  initial begin
    repeat (3) @(negedge clock);
    #1;
    check_reset_outputs();
    release_reset();
    wait_ready(20000);

    issue(8'd5, 7'd5, 1'b0, 1'b1, 1'b0);
    wait_ready(100);
    issue(8'd4, 7'd5, 1'b1, 1'b1, 1'b0);
    wait_ready(100);
    issue(8'd157, 7'd118, 1'b0, 1'b1, 1'b0);
    wait_ready(100);
    issue(8'd154, 7'd114, 1'b0, 1'b1, 1'b0);
    wait_ready(100);

    for (int i = 0; i < 16; i++) begin
      issue(8'($urandom_range(0, 255)), 7'($urandom_range(0, 127)),
            1'($urandom_range(0, 1)), 1'b1, 1'b0);
      repeat ($urandom_range(0, 2)) begin
        @(negedge clock); #1;
      end
      wait_ready(100);
    end

    // clear_req wins over a simultaneous req
    issue(8'd40, 7'd40, 1'b0, 1'b1, 1'b1);
    wait_ready(20000);

    // reset in the tenth cycle of a draw aborts it
    issue(8'd20, 7'd30, 1'b0, 1'b1, 1'b0);
    repeat (10) @(negedge clock);
    #1;
    exp_q.delete();
    done_q.delete();
    reset_n = 1'b1;
    repeat (2) @(negedge clock);
    #1;
    check_reset_outputs();
    release_reset();
    wait_ready(20000);

    issue(8'd100, 7'd60, 1'b0, 1'b1, 1'b0);
    wait_ready(100);

    repeat (5) @(negedge clock);
    #1;
    check("exp_q_empty", exp_q.size(), 0);
    check("done_q_empty", done_q.size(), 0);

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
